// File: rtl/slave_pkg.sv
// Shared types and default widths for the slave side of the two-master/two-slave
// valid/ready interconnect.
package slave_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 3;
   localparam int CNT_W_DEF  = 8;
   localparam int WAIT_W     = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_READY = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] value;
   } slave_req_t;

endpackage

// File: rtl/slave_endpoint_if.sv
// Valid/ready request channel between one interconnect slave port and its endpoint.
interface slave_endpoint_if
   import slave_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              valid_in;
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] value_in;
   logic              ready_out;

   modport master (output valid_in, output addr_in, output value_in, input ready_out);
   modport slave  (input valid_in, input addr_in, input value_in, output ready_out);
endinterface

// File: rtl/slave_regfile.sv
// Register file: one synchronous write port, one combinational read port, no bypass.
module slave_regfile
   import slave_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Storage update: clear everything on reset, otherwise commit the write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];
endmodule

// File: rtl/slave_endpoint.sv
// Slave-side responder: wait-state insertion, snapshot-based commit into the
// register file, write counter and sticky interconnect protocol-violation flag.
module slave_endpoint
   import slave_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   slave_endpoint_if.slave   bus,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  wr_count,
   output logic              proto_err
);
   localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

   state_e              state_r, next_state_s;
   logic [WAIT_W-1:0]   cnt_r, cnt_nxt_s;
   logic [ADDR_W-1:0]   snap_addr_r;
   logic [DATA_W-1:0]   snap_value_r;
   logic [CNT_W-1:0]    wr_count_r;
   logic                proto_err_r;
   logic                ready_r;
   logic                snap_ld_s;
   logic                wr_en_s;
   logic                err_set_s;
   logic                mismatch_s;

   assign mismatch_s = (bus.addr_in != snap_addr_r) || (bus.value_in != snap_value_r);

   // Next-state, wait counter and commit/error decisions.
   always_comb begin
      next_state_s = state_r;
      cnt_nxt_s    = cnt_r;
      snap_ld_s    = 1'b0;
      wr_en_s      = 1'b0;
      err_set_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (bus.valid_in) begin
               snap_ld_s = 1'b1;
               cnt_nxt_s = WAIT_LD;
               if (WAIT_LD == 4'd0) begin
                  next_state_s = S_READY;
               end else begin
                  next_state_s = S_WAIT;
               end
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!bus.valid_in) begin
               err_set_s    = 1'b1;
               cnt_nxt_s    = 4'd0;
               next_state_s = S_IDLE;
            end else begin
               err_set_s = mismatch_s;
               if (cnt_r <= 4'd1) begin
                  cnt_nxt_s    = 4'd0;
                  next_state_s = S_READY;
               end else begin
                  cnt_nxt_s    = cnt_r - 4'd1;
                  next_state_s = S_WAIT;
               end
            end
         end
         S_READY: begin
            // Committed data always comes from the snapshot, even if the bus drifted.
            if (!bus.valid_in) begin
               err_set_s    = 1'b1;
               next_state_s = S_IDLE;
            end else begin
               err_set_s    = mismatch_s;
               wr_en_s      = 1'b1;
               next_state_s = S_IDLE;
            end
         end
         default: begin
            next_state_s = S_IDLE;
            cnt_nxt_s    = 4'd0;
         end
      endcase
   end

   // State, snapshot, ready, counter and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         cnt_r        <= 4'd0;
         snap_addr_r  <= '0;
         snap_value_r <= '0;
         wr_count_r   <= '0;
         proto_err_r  <= 1'b0;
         ready_r      <= 1'b0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= cnt_nxt_s;
         ready_r <= (next_state_s == S_READY);
         if (snap_ld_s) begin
            snap_addr_r  <= bus.addr_in;
            snap_value_r <= bus.value_in;
         end
         if (wr_en_s) begin
            wr_count_r <= wr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (err_set_s) begin
            proto_err_r <= 1'b1;
         end
      end
   end

   assign bus.ready_out = ready_r;
   assign wr_count      = wr_count_r;
   assign proto_err     = proto_err_r;

   slave_regfile #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s),
      .wr_addr (snap_addr_r),
      .wr_data (snap_value_r),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
endmodule

// File: tb/tb_slave_endpoint.sv
// Self-checking bench: a WAIT_CYCLES=2 endpoint driven with directed and random
// transactions, plus a WAIT_CYCLES=0 endpoint for back-to-back traffic.
module tb_slave_endpoint;
   localparam int W2 = 2;

   logic clk;
   logic rst;

   slave_endpoint_if #(.ADDR_W(3), .DATA_W(3)) if2 ();
   slave_endpoint_if #(.ADDR_W(3), .DATA_W(3)) if0 ();

   logic [2:0] rd_addr2, rd_data2, rd_addr0, rd_data0;
   logic [7:0] wr_count2, wr_count0;
   logic       proto_err2, proto_err0;

   slave_endpoint #(.ADDR_W(3), .DATA_W(3), .WAIT_CYCLES(W2), .CNT_W(8)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .bus       (if2.slave),
      .rd_addr   (rd_addr2),
      .rd_data   (rd_data2),
      .wr_count  (wr_count2),
      .proto_err (proto_err2)
   );

   slave_endpoint #(.ADDR_W(3), .DATA_W(3), .WAIT_CYCLES(0), .CNT_W(8)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (if0.slave),
      .rd_addr   (rd_addr0),
      .rd_data   (rd_data0),
      .wr_count  (wr_count0),
      .proto_err (proto_err0)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model of the WAIT_CYCLES=2 endpoint.
   logic [2:0] m2_mem [8];
   int         m2_cnt;
   bit         m2_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m2_mem[i] = 3'd0;
      m2_cnt = 0;
      m2_err = 1'b0;
   endtask

   // One transaction on dut2; optionally corrupt value_in at wait cycle bad_cyc.
   task automatic do_txn2(input logic [2:0] a, input logic [2:0] v,
                          input int bad_cyc, input logic [2:0] bad_v);
      logic [2:0] old;
      @(negedge clk);
      if2.valid_in = 1'b1;
      if2.addr_in  = a;
      if2.value_in = v;
      for (int c = 1; c <= W2 + 1; c++) begin
         @(negedge clk);
         n_checks++;
         if (if2.ready_out !== (c == W2 + 1)) begin
            n_fail++;
            $display("FAIL ready_timing cyc=%0d got=%b exp=%b", c, if2.ready_out, (c == W2 + 1));
         end
         if (c == bad_cyc) begin
            if2.value_in = bad_v;
            m2_err = 1'b1;
         end
      end
      rd_addr2 = a;
      #1;
      old = m2_mem[a];
      n_checks++;
      if (rd_data2 !== old) begin
         n_fail++;
         $display("FAIL no_bypass addr=%0d got=%0d exp=%0d", a, rd_data2, old);
      end
      @(negedge clk);
      if2.valid_in = 1'b0;
      m2_mem[a] = v;
      m2_cnt = (m2_cnt + 1) % 256;
      n_checks++;
      if (if2.ready_out !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_drop got=%b exp=0", if2.ready_out);
      end
      n_checks++;
      if (rd_data2 !== m2_mem[a]) begin
         n_fail++;
         $display("FAIL mem_write addr=%0d got=%0d exp=%0d", a, rd_data2, m2_mem[a]);
      end
      n_checks++;
      if (wr_count2 !== 8'(m2_cnt)) begin
         n_fail++;
         $display("FAIL wr_count got=%0d exp=%0d", wr_count2, m2_cnt);
      end
      n_checks++;
      if (proto_err2 !== m2_err) begin
         n_fail++;
         $display("FAIL proto_err got=%b exp=%b", proto_err2, m2_err);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         rd_addr2 = 3'(i);
         #1;
         n_checks++;
         if (rd_data2 !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_mem addr=%0d got=%0d exp=0", tag, i, rd_data2);
         end
      end
      n_checks++;
      if (if2.ready_out !== 1'b0 || wr_count2 !== 8'd0 || proto_err2 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_regs ready=%b cnt=%0d err=%b exp=0/0/0", tag,
                  if2.ready_out, wr_count2, proto_err2);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_all_zero("reset");
   endtask

   task automatic test_basic();
      do_txn2(3'd5, 3'd3, 0, 3'd0);
   endtask

   task automatic test_drop_valid();
      logic [2:0] a;
      a = 3'($urandom_range(0, 7));
      @(negedge clk);
      if2.valid_in = 1'b1;
      if2.addr_in  = a;
      if2.value_in = ~m2_mem[a];
      @(negedge clk);
      if2.valid_in = 1'b0;
      @(negedge clk);
      m2_err = 1'b1;
      rd_addr2 = a;
      #1;
      n_checks++;
      if (proto_err2 !== 1'b1 || if2.ready_out !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_err err=%b ready=%b exp=1/0", proto_err2, if2.ready_out);
      end
      n_checks++;
      if (wr_count2 !== 8'(m2_cnt) || rd_data2 !== m2_mem[a]) begin
         n_fail++;
         $display("FAIL drop_nowrite cnt=%0d mem=%0d exp=%0d/%0d", wr_count2, rd_data2,
                  m2_cnt, m2_mem[a]);
      end
      do_txn2(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0, 3'd0);
   endtask

   task automatic test_value_change();
      do_txn2(3'd4, 3'd3, 1, 3'd6);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      if0.valid_in = 1'b1;
      if0.addr_in  = 3'd1;
      if0.value_in = 3'd7;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (if0.ready_out !== (c == 1 || c == 3)) begin
            n_fail++;
            $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, if0.ready_out, (c == 1 || c == 3));
         end
         if (c == 2) begin
            if0.addr_in  = 3'd2;
            if0.value_in = 3'd4;
         end
         if (c == 4) if0.valid_in = 1'b0;
      end
      rd_addr0 = 3'd1;
      #1;
      n_checks++;
      if (rd_data0 !== 3'd7) begin
         n_fail++;
         $display("FAIL b2b_mem1 got=%0d exp=7", rd_data0);
      end
      rd_addr0 = 3'd2;
      #1;
      n_checks++;
      if (rd_data0 !== 3'd4 || wr_count0 !== 8'd2 || proto_err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_state mem2=%0d cnt=%0d err=%b exp=4/2/0", rd_data0, wr_count0, proto_err0);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      if2.valid_in = 1'b1;
      if2.addr_in  = 3'd6;
      if2.value_in = 3'd5;
      repeat (W2 + 1) @(negedge clk);
      n_checks++;
      if (if2.ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_ready got=%b exp=1", if2.ready_out);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if2.valid_in = 1'b0;
      model_reset();
      check_all_zero("mid_reset");
   endtask

   task automatic test_wrap();
      for (int n = 0; n < 256; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_txn2(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0, 3'd0);
      end
      n_checks++;
      if (wr_count2 !== 8'd0) begin
         n_fail++;
         $display("FAIL wrap got=%0d exp=0", wr_count2);
      end
   endtask

   initial begin
      rst = 1'b1;
      if2.valid_in = 1'b0; if2.addr_in = 3'd0; if2.value_in = 3'd0;
      if0.valid_in = 1'b0; if0.addr_in = 3'd0; if0.value_in = 3'd0;
      rd_addr2 = 3'd0;
      rd_addr0 = 3'd0;
      test_reset();
      test_basic();
      test_drop_valid();
      test_value_change();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/slave_endpoint.md
Name: slave_endpoint

Overview:
- Slave-side responder for the two-master/two-slave valid/ready interconnect; one instance sits behind each slave port (valid_slaveN, addr_out, value_out in, ready_slaveN out).
- Inserts a configurable number of wait states before asserting ready.
- Commits each handshaken (addr, value) pair into an 8-entry register file, exposes a read port and a write counter, and flags protocol violations by the interconnect.

Parameters:
- ADDR_W, 3, address width; register file depth is 2**ADDR_W.
- DATA_W, 3, value width.
- WAIT_CYCLES, 2, cycles between first sampled valid and ready assertion; legal range 0..15.
- CNT_W, 8, width of the write counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  transaction valid from interconnect.
- addr_in  in  ADDR_W  target register address.
- value_in  in  DATA_W  write data.
- ready_out  out  1  slave ready; registered, decoded from state.
- rd_addr  in  ADDR_W  register file read address.
- rd_data  out  DATA_W  combinational read of mem[rd_addr].
- wr_count  out  CNT_W  number of committed writes; wraps at 2**CNT_W.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=S_IDLE, ready_out=0, wait counter=0, all mem entries=0, wr_count=0, proto_err=0, snapshot regs=0.
- Reset asserted mid-transaction aborts it: no write, no error, ready_out=0 the next cycle.
- Handshake = valid_in & ready_out in the same cycle.
- S_IDLE: ready_out=0.
  - If valid_in=1 at edge T, capture addr_in/value_in into snapshot.
  - Load cnt=WAIT_CYCLES.
  - Go to S_READY if WAIT_CYCLES==0, else S_WAIT.
- S_WAIT: ready_out=0; cnt decrements each cycle; when cnt==1, go to S_READY.
  - Net latency: ready_out first high in cycle T+1+WAIT_CYCLES.
- S_READY: ready_out=1. On handshake:
  - mem[snap_addr] <= snap_value.
  - wr_count <= wr_count+1, wrapping.
  - Go to S_IDLE, so ready_out=0 the following cycle.
- Minimum spacing: one S_IDLE cycle between transactions.
  - If valid_in stays high in that S_IDLE cycle, it is treated as a new transaction and captured there.
- Protocol checks, in S_WAIT and S_READY:
  - valid_in=0 before handshake: set proto_err, go to S_IDLE, no write.
  - addr_in or value_in differs from snapshot while valid_in=1: set proto_err; the transaction continues and the snapshot value is written.
  - proto_err clears only on rst.
- Read port: rd_data is combinational.
  - A write at edge E is visible from the cycle after E.
  - rd_addr equal to the address being written in the same cycle returns the old value; no bypass.
- wr_count at 2**CNT_W-1 plus one write gives 0; no flag is raised.

Decomposition:
- Shared package slave_pkg:
  - state enum (S_IDLE, S_WAIT, S_READY) as 2-bit logic.
  - Default widths ADDR_W/DATA_W.
  - A packed struct {addr, value} reused by the interconnect.
- Sub-module slave_regfile: 2**ADDR_W x DATA_W, one synchronous write port, one combinational read port, synchronous reset to zero.
- The FSM, wait counter, snapshot, checker and counter stay in slave_endpoint.

Test Plan:
- WAIT_CYCLES=2; valid_in=1, addr=5, value=3 held from cycle 10 -> ready_out high in cycle 13 only; mem[5]=3 readable in cycle 14; wr_count=1; proto_err=0.
- WAIT_CYCLES=0; valid held high with addr=1/val=7 then addr=2/val=4 back-to-back -> ready pulses at cycles T+1 and T+3; mem[1]=7, mem[2]=4; wr_count=2.
- valid_in dropped in S_WAIT (cycle T+1, WAIT_CYCLES=2) -> proto_err=1 from the next cycle; no write; wr_count unchanged; the next clean transaction still completes.
- value_in changed from 3 to 6 while waiting on addr=4 -> proto_err=1; mem[4]=3 after handshake.
- rst pulsed for one cycle while in S_READY -> ready_out=0 the next cycle; all mem=0, wr_count=0, proto_err=0.
- 256 writes with CNT_W=8 -> wr_count wraps to 0; rd_addr equal to the write address in the write cycle returns the pre-write value.
